// File: rtl/nav_button_cond_if.sv
// ---------------------------------------------------------------------------
// nav_button_cond_if
//   Signal bundle between the board-side navigation buttons and the button
//   conditioner.
//
//   btn_left_raw   raw left button pin (asynchronous, active-high)
//   btn_right_raw  raw right button pin (asynchronous, active-high)
//   left           one-cycle pulse, accepted left press
//   right          one-cycle pulse, accepted right press
//   left_held      debounced left level
//   right_held     debounced right level
//
//   master : drives the raw pins and observes the conditioned outputs
//   slave  : the conditioner itself
// ---------------------------------------------------------------------------
interface nav_button_cond_if;
    logic btn_left_raw;
    logic btn_right_raw;
    logic left;
    logic right;
    logic left_held;
    logic right_held;

    modport master (
        output btn_left_raw,
        output btn_right_raw,
        input  left,
        input  right,
        input  left_held,
        input  right_held
    );

    modport slave (
        input  btn_left_raw,
        input  btn_right_raw,
        output left,
        output right,
        output left_held,
        output right_held
    );
endinterface

// File: rtl/nav_button_cond.sv
// ---------------------------------------------------------------------------
// nav_button_cond
//   Conditions the two raw navigation push-buttons for the menu selector.
//   Each button passes through a 2-FF synchroniser, a debounce counter and a
//   per-button press FSM that emits a registered one-cycle pulse when a press
//   is accepted. If both buttons would pulse on the same edge, both pulses
//   are dropped so the menu never sees left and right together.
//
//   Optional feature macro: AUTO_REPEAT_EN
//     defined   : a held button produces extra pulses, the first after
//                 REPEAT_DELAY cycles in HELD, then one every REPEAT_PERIOD.
//     undefined : exactly one pulse per accepted press; no repeat logic.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept a level change (>= 2)
//   REPEAT_DELAY     HELD cycles before the first auto-repeat pulse
//   REPEAT_PERIOD    cycles between subsequent auto-repeat pulses
//
// Ports
//   clk   system clock
//   rst   asynchronous, active-high reset
//   nav   slave side of nav_button_cond_if (raw pins in, pulses/levels out)
// ---------------------------------------------------------------------------
module nav_button_cond #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 20_000_000
) (
    input  logic              clk,
    input  logic              rst,
    nav_button_cond_if.slave  nav
);

    // Debounce counter sizing; DEBOUNCE_CYCLES-1 is the terminal count.
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Per-button press FSM encoding.
    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

`ifdef AUTO_REPEAT_EN
    // Repeat counter sizing; must hold the larger of the two terminal counts.
    localparam int            REP_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW          = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;
    localparam logic [RW-1:0] REP_ZERO    = {RW{1'b0}};
    localparam logic [RW-1:0] REP_ONE     = RW'(1);
    localparam logic [RW-1:0] REP_DLY_END = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_PER_END = RW'(REPEAT_PERIOD - 1);
`endif

    // Reject parameter values the counters cannot represent.
    if ((DEBOUNCE_CYCLES < 2) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_params
        $error("nav_button_cond: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* >= 1");
    end

    // Bit 0 is the left button, bit 1 is the right button throughout.
    logic [1:0] raw_s;
    logic [1:0] sync1_r;
    logic [1:0] sync2_r;
    logic [1:0] press_s;
    logic [1:0] held_s;
    logic       left_r;
    logic       right_r;

    assign raw_s = {nav.btn_right_raw, nav.btn_left_raw};

    // Two-stage synchroniser for the asynchronous button pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic [1:0]    state_r;
        logic [1:0]    state_nxt_s;
        logic [CW-1:0] cnt_r;
        logic [CW-1:0] cnt_nxt_s;
        logic          held_r;
        logic          held_nxt_s;
        logic          differ_s;
        logic          done_s;
        logic          accept_s;
        logic          rep_fire_s;

        // Debounce: count consecutive cycles where the synchronised level
        // disagrees with the accepted level; any agreement restarts the count.
        always_comb begin
            differ_s   = sync2_r[i] ^ held_r;
            done_s     = 1'b0;
            cnt_nxt_s  = CNT_ZERO;
            held_nxt_s = held_r;
            if (!differ_s) begin
                cnt_nxt_s  = CNT_ZERO;
                held_nxt_s = held_r;
            end else if (cnt_r == CNT_LAST) begin
                done_s     = 1'b1;
                cnt_nxt_s  = CNT_ZERO;
                held_nxt_s = sync2_r[i];
            end else begin
                cnt_nxt_s  = cnt_r + CNT_ONE;
                held_nxt_s = held_r;
            end
        end

        // Press FSM: the WAIT states mirror the debounce counter running;
        // accept_s marks the single PRESS_WAIT -> HELD transition.
        always_comb begin
            state_nxt_s = state_r;
            accept_s    = 1'b0;
            case (state_r)
                ST_RELEASED: begin
                    if (sync2_r[i]) begin
                        state_nxt_s = ST_PRESS_WAIT;
                    end else begin
                        state_nxt_s = ST_RELEASED;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!sync2_r[i]) begin
                        state_nxt_s = ST_RELEASED;
                    end else if (done_s) begin
                        state_nxt_s = ST_HELD;
                        accept_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_PRESS_WAIT;
                    end
                end
                ST_HELD: begin
                    if (!sync2_r[i]) begin
                        state_nxt_s = ST_RELEASE_WAIT;
                    end else begin
                        state_nxt_s = ST_HELD;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (sync2_r[i]) begin
                        state_nxt_s = ST_HELD;
                    end else if (done_s) begin
                        state_nxt_s = ST_RELEASED;
                    end else begin
                        state_nxt_s = ST_RELEASE_WAIT;
                    end
                end
                default: begin
                    state_nxt_s = ST_RELEASED;
                end
            endcase
        end

        // FSM state, debounce counter and accepted level.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_r <= ST_RELEASED;
                cnt_r   <= CNT_ZERO;
                held_r  <= 1'b0;
            end else begin
                state_r <= state_nxt_s;
                cnt_r   <= cnt_nxt_s;
                held_r  <= held_nxt_s;
            end
        end

`ifdef AUTO_REPEAT_EN
        logic [RW-1:0] rep_cnt_r;
        logic          rep_armed_r;

        // Repeat strobe: only while HELD with the pin still high, so no
        // repeat slips out once the release has reached the synchroniser.
        always_comb begin
            rep_fire_s = 1'b0;
            if ((state_r == ST_HELD) && sync2_r[i]) begin
                if (rep_armed_r) begin
                    rep_fire_s = (rep_cnt_r == REP_PER_END);
                end else begin
                    rep_fire_s = (rep_cnt_r == REP_DLY_END);
                end
            end else begin
                rep_fire_s = 1'b0;
            end
        end

        // Repeat counter: cleared outside HELD so every entry to HELD
        // restarts the initial delay; after the first repeat it is armed
        // and counts the shorter period.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rep_cnt_r   <= REP_ZERO;
                rep_armed_r <= 1'b0;
            end else if (state_r != ST_HELD) begin
                rep_cnt_r   <= REP_ZERO;
                rep_armed_r <= 1'b0;
            end else if (rep_fire_s) begin
                rep_cnt_r   <= REP_ZERO;
                rep_armed_r <= 1'b1;
            end else begin
                rep_cnt_r   <= rep_cnt_r + REP_ONE;
                rep_armed_r <= rep_armed_r;
            end
        end
`else
        assign rep_fire_s = 1'b0;
`endif

        assign press_s[i] = accept_s | rep_fire_s;
        assign held_s[i]  = held_r;
    end

    // Output pulses: a coincident left/right request cancels both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_r  <= 1'b0;
            right_r <= 1'b0;
        end else begin
            left_r  <= press_s[0] & ~press_s[1];
            right_r <= press_s[1] & ~press_s[0];
        end
    end

    assign nav.left       = left_r;
    assign nav.right      = right_r;
    assign nav.left_held  = held_s[0];
    assign nav.right_held = held_s[1];

endmodule

// File: tb/tb_nav_button_cond.sv
// ---------------------------------------------------------------------------
// tb_nav_button_cond
//   Directed-vector bench for nav_button_cond with DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=10, REPEAT_PERIOD=3. Each vector drives the two raw pins,
//   lets one rising edge pass, then compares the packed output word
//   {left, right, left_held, right_held} 1 ns later against a hand-computed
//   value. A raw level applied in vector k is first sampled at edge k, so an
//   accepted press pulses after edge k+5 and clears after edge k+6.
//   The auto-repeat section is compiled only with AUTO_REPEAT_EN.
// ---------------------------------------------------------------------------
module tb_nav_button_cond;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    nav_button_cond_if nav ();

    nav_button_cond #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .nav (nav.slave)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    function automatic logic [3:0] obs();
        return {nav.left, nav.right, nav.left_held, nav.right_held};
    endfunction

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {l,r,lh,rh}=%b expected %b", tag, got, exp);
        end
    endtask

    // One vector: apply raw pins, pass one rising edge, compare 1 ns later.
    task automatic cyc(input string tag, input logic l_raw, input logic r_raw, input logic [3:0] exp);
        nav.btn_left_raw  = l_raw;
        nav.btn_right_raw = r_raw;
        @(posedge clk);
        #1;
        check_val(tag, obs(), exp);
    endtask

    logic p;

    // Directed stimulus sequence.
    initial begin
        rst               = 1'b1;
        nav.btn_left_raw  = 1'b0;
        nav.btn_right_raw = 1'b0;

        // Reset holds everything low even with both pins pressed.
        #1;
        check_val("reset_initial", obs(), 4'b0000);
        for (int j = 0; j < 3; j++) cyc("reset_pressed", 1'b1, 1'b1, 4'b0000);
        rst = 1'b0;
        for (int j = 0; j < 6; j++) cyc("idle", 1'b0, 1'b0, 4'b0000);

        // 1: clean right press, pulse after edge k+5 only.
        for (int j = 0; j < 5; j++) cyc("t1_debounce", 1'b0, 1'b1, 4'b0000);
        cyc("t1_pulse", 1'b0, 1'b1, 4'b0101);
        for (int j = 0; j < 3; j++) cyc("t1_hold", 1'b0, 1'b1, 4'b0001);
        for (int j = 0; j < 5; j++) cyc("t1_release", 1'b0, 1'b0, 4'b0001);
        cyc("t1_released", 1'b0, 1'b0, 4'b0000);
        cyc("t1_idle", 1'b0, 1'b0, 4'b0000);

        // 2: left bounces 1,0,1,0 then rises for good; pulse 5 edges after final rise.
        cyc("t2_bounce", 1'b1, 1'b0, 4'b0000);
        cyc("t2_bounce", 1'b0, 1'b0, 4'b0000);
        cyc("t2_bounce", 1'b1, 1'b0, 4'b0000);
        cyc("t2_bounce", 1'b0, 1'b0, 4'b0000);
        cyc("t2_final_rise", 1'b1, 1'b0, 4'b0000);
        for (int j = 0; j < 4; j++) cyc("t2_debounce", 1'b1, 1'b0, 4'b0000);
        cyc("t2_pulse", 1'b1, 1'b0, 4'b1010);
        cyc("t2_hold", 1'b1, 1'b0, 4'b0010);

        // 3: release with a 0,1,0 bounce; left_held falls 5 edges after the
        //    final falling sample, never a pulse.
        cyc("t3_bounce", 1'b0, 1'b0, 4'b0010);
        cyc("t3_bounce", 1'b1, 1'b0, 4'b0010);
        cyc("t3_final_fall", 1'b0, 1'b0, 4'b0010);
        for (int j = 0; j < 4; j++) cyc("t3_debounce", 1'b0, 1'b0, 4'b0010);
        cyc("t3_held_fall", 1'b0, 1'b0, 4'b0000);
        cyc("t3_idle", 1'b0, 1'b0, 4'b0000);

        // 4: both pins rise together; both pulses suppressed, both levels rise.
        for (int j = 0; j < 5; j++) cyc("t4_debounce", 1'b1, 1'b1, 4'b0000);
        for (int j = 0; j < 4; j++) cyc("t4_both_held", 1'b1, 1'b1, 4'b0011);
        for (int j = 0; j < 5; j++) cyc("t4_release", 1'b0, 1'b0, 4'b0011);
        cyc("t4_released", 1'b0, 1'b0, 4'b0000);
        cyc("t4_idle", 1'b0, 1'b0, 4'b0000);

        // Right pressed one edge after left: each gets its own pulse.
        cyc("ov_left_first", 1'b1, 1'b0, 4'b0000);
        for (int j = 0; j < 4; j++) cyc("ov_debounce", 1'b1, 1'b1, 4'b0000);
        cyc("ov_left_pulse", 1'b1, 1'b1, 4'b1010);
        cyc("ov_right_pulse", 1'b1, 1'b1, 4'b0111);
        cyc("ov_both_held", 1'b1, 1'b1, 4'b0011);
        for (int j = 0; j < 5; j++) cyc("ov_release", 1'b0, 1'b0, 4'b0011);
        cyc("ov_released", 1'b0, 1'b0, 4'b0000);

        // rst mid-hold: outputs clear without a clock edge; the still-pressed
        // button re-debounces and pulses once after release of rst.
        for (int j = 0; j < 5; j++) cyc("rh_debounce", 1'b0, 1'b1, 4'b0000);
        cyc("rh_pulse", 1'b0, 1'b1, 4'b0101);
        cyc("rh_hold", 1'b0, 1'b1, 4'b0001);
        rst = 1'b1;
        #1;
        check_val("rh_async_clear", obs(), 4'b0000);
        for (int j = 0; j < 2; j++) cyc("rh_in_reset", 1'b0, 1'b1, 4'b0000);
        rst = 1'b0;
        for (int j = 0; j < 5; j++) cyc("rh_redebounce", 1'b0, 1'b1, 4'b0000);
        cyc("rh_repulse", 1'b0, 1'b1, 4'b0101);
        cyc("rh_rehold", 1'b0, 1'b1, 4'b0001);
        for (int j = 0; j < 5; j++) cyc("rh_release", 1'b0, 1'b0, 4'b0001);
        cyc("rh_released", 1'b0, 1'b0, 4'b0000);

        // 5: rst while left debounce count is 2; full debounce again afterwards.
        for (int j = 0; j < 4; j++) cyc("t5_debounce", 1'b1, 1'b0, 4'b0000);
        rst = 1'b1;
        #1;
        check_val("t5_async_clear", obs(), 4'b0000);
        cyc("t5_in_reset", 1'b1, 1'b0, 4'b0000);
        rst = 1'b0;
        for (int j = 0; j < 5; j++) cyc("t5_redebounce", 1'b1, 1'b0, 4'b0000);
        cyc("t5_pulse", 1'b1, 1'b0, 4'b1010);
        cyc("t5_hold", 1'b1, 1'b0, 4'b0010);
        for (int j = 0; j < 5; j++) cyc("t5_release", 1'b0, 1'b0, 4'b0010);
        cyc("t5_released", 1'b0, 1'b0, 4'b0000);

`ifdef AUTO_REPEAT_EN
        // 6: right held; pulses at HELD+0, +10, +13, ... and none after release.
        for (int j = 0; j < 5; j++) cyc("t6_debounce", 1'b0, 1'b1, 4'b0000);
        for (int j = 0; j < 29; j++) begin
            p = (j == 0) || ((j >= 10) && (((j - 10) % 3) == 0));
            cyc("t6_repeat", 1'b0, 1'b1, {1'b0, p, 1'b0, 1'b1});
        end
        for (int j = 29; j < 34; j++) cyc("t6_release", 1'b0, 1'b0, 4'b0001);
        for (int j = 0; j < 5; j++) cyc("t6_released", 1'b0, 1'b0, 4'b0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
